// File: rtl/slave_port_burst.sv
// slave_port_burst: serial-header bus slave port with burst
// auto-increment and split signalling on long read delays.
module slave_port_burst #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int BURST_W      = 12,
  parameter int DELAY_W      = 6,
  parameter int SPLIT_THRESH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DELAY_W-1:0] slave_delay,
  input  logic               read_en,
  input  logic               write_en,
  input  logic               master_valid,
  input  logic               master_ready,
  output logic               slave_ready,
  output logic               slave_valid,
  input  logic               rx_address,
  input  logic               rx_burst,
  input  logic               rx_data,
  output logic               tx_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               split_en,
  output logic               done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;
  localparam logic [2:0] RREQ  = 3'd5;
  localparam logic [2:0] RLOAD = 3'd6;
  localparam logic [2:0] RTX   = 3'd7;

  localparam int HW = $clog2(ADDR_W + 1);
  localparam int BW = $clog2(DATA_W);
  localparam logic [HW-1:0] HLAST = HW'(ADDR_W - 1);
  localparam logic [HW-1:0] BMAX  = HW'(BURST_W);
  localparam logic [BW-1:0] DLAST = BW'(DATA_W - 1);
  localparam logic [DELAY_W-1:0] SPLIT_D = DELAY_W'(SPLIT_THRESH);
  localparam logic [DELAY_W-1:0] D_ONE   = DELAY_W'(1);

  logic [2:0]         state;
  logic [HW-1:0]      hcnt;
  logic [BW-1:0]      bcnt;
  logic [ADDR_W-1:0]  addr;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] beats;
  logic [DELAY_W-1:0] dly;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  rdata;
  logic               is_rd;
  logic               split;

  logic               start;
  logic               hdr_bit;
  logic               hdr_last;
  logic               rd_now;
  logic               bit_last;
  logic               beat_last;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [BURST_W-1:0] nxt_burst;

  assign start     = (state == IDLE) && master_valid
                     && (read_en ^ write_en);
  assign hdr_bit   = start || ((state == HDR) && master_valid);
  assign hdr_last  = hdr_bit && (hcnt == HLAST);
  assign rd_now    = (state == IDLE) ? read_en : is_rd;
  assign bit_last  = (bcnt == DLAST);
  assign beat_last = (beats == '0);
  assign nxt_addr  = {rx_address, addr[ADDR_W-1:1]};
  // Burst bits past the field width are simply not shifted in.
  assign nxt_burst = (hcnt < BMAX)
                     ? {rx_burst, burst[BURST_W-1:1]}
                     : burst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      bcnt  <= '0;
      addr  <= '0;
      burst <= '0;
      beats <= '0;
      dly   <= '0;
      wdata <= '0;
      rdata <= '0;
      is_rd <= 1'b0;
      split <= 1'b0;
    end else begin
      case (state)
        IDLE, HDR: begin
          if (hdr_bit) begin
            addr  <= nxt_addr;
            burst <= nxt_burst;
            is_rd <= rd_now;
            if (hdr_last) begin
              hcnt  <= '0;
              bcnt  <= '0;
              beats <= nxt_burst;
              dly   <= slave_delay;
              split <= (slave_delay >= SPLIT_D);
              if (!rd_now)
                state <= WDATA;
              else if (slave_delay == '0)
                state <= RREQ;
              else
                state <= RWAIT;
            end else begin
              hcnt  <= hcnt + 1'b1;
              state <= HDR;
            end
          end
        end
        WDATA: begin
          if (master_valid) begin
            wdata <= {rx_data, wdata[DATA_W-1:1]};
            bcnt  <= bit_last ? '0 : bcnt + 1'b1;
            if (bit_last)
              state <= WRITE;
          end
        end
        WRITE: begin
          if (beat_last) begin
            state <= IDLE;
          end else begin
            addr  <= addr + 1'b1;
            beats <= beats - 1'b1;
            state <= WDATA;
          end
        end
        RWAIT: begin
          dly <= dly - 1'b1;
          if (dly == D_ONE)
            state <= RREQ;
        end
        RREQ: state <= RLOAD;
        RLOAD: begin
          rdata <= mem_rdata;
          state <= RTX;
        end
        RTX: begin
          if (master_ready) begin
            rdata <= rdata >> 1;
            bcnt  <= bit_last ? '0 : bcnt + 1'b1;
            if (bit_last) begin
              if (beat_last) begin
                state <= IDLE;
              end else begin
                addr  <= addr + 1'b1;
                beats <= beats - 1'b1;
                state <= RREQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign slave_ready = (state == IDLE);
  assign slave_valid = (state == RTX);
  assign tx_data     = (state == RTX) && rdata[0];
  assign mem_addr    = addr;
  assign mem_wdata   = wdata;
  assign mem_wr      = (state == WRITE);
  assign mem_rd      = (state == RREQ);
  assign split_en    = (state == RWAIT) && split;
  assign done        = ((state == WRITE) && beat_last)
                       || ((state == RTX) && master_ready
                           && bit_last && beat_last);

endmodule

// File: tb/tb_slave_port_burst.sv
// tb_slave_port_burst: transaction planner builds per-cycle stimulus and
// expected outputs from the protocol rules; a checker compares every cycle.
module tb_slave_port_burst;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int BWD  = 12;
  localparam int DLW  = 6;
  localparam int TH   = 5;
  localparam int MAXC = 12000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [DLW-1:0] slave_delay = '0;
  logic           read_en = 1'b0;
  logic           write_en = 1'b0;
  logic           master_valid = 1'b0;
  logic           master_ready = 1'b0;
  logic           slave_ready;
  logic           slave_valid;
  logic           rx_address = 1'b0;
  logic           rx_burst = 1'b0;
  logic           rx_data = 1'b0;
  logic           tx_data;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_wr;
  logic           mem_rd;
  logic [DW-1:0]  mem_rdata = '0;
  logic           split_en;
  logic           done;

  slave_port_burst #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BWD),
    .DELAY_W(DLW), .SPLIT_THRESH(TH)
  ) dut (
    .clk(clk), .reset(reset), .slave_delay(slave_delay),
    .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .master_ready(master_ready),
    .slave_ready(slave_ready), .slave_valid(slave_valid),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .tx_data(tx_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .split_en(split_en), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst; logic mv; logic mr; logic re; logic we;
    logic rxa; logic rxb; logic rxd; logic [DLW-1:0] dly;
  } stim_t;

  typedef struct packed {
    logic rdy; logic vld; logic tx; logic wr; logic rd;
    logic split; logic done; logic chk_a; logic chk_d;
    logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } exp_t;

  stim_t st [MAXC];
  exp_t  ex [MAXC];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] ram       [0:(1<<AW)-1];

  logic          obs_wr [MAXC];
  logic          obs_rd [MAXC];
  logic          obs_split [MAXC];
  logic          obs_done [MAXC];
  logic          obs_tx [MAXC];
  logic [AW-1:0] obs_addr [MAXC];

  int pc = 0;
  int stall_pct = 0;
  int total = 0;
  int bad = 0;
  int cur_k = -1;
  int ncyc;
  int s_w1, s_r1, s_r2, e_r2, s_b, e_b, s_rst, e_rst;

  // Memory: writes land on mem_wr, read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] = mem_wdata;
    mem_rdata <= mem_rd ? ram[mem_addr] : DW'($urandom);
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, k, act, req);
    end
  endtask

  function automatic stim_t junk();
    logic [31:0] r;
    stim_t s;
    r = $urandom;
    s = r[$bits(stim_t)-1:0];
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic bit stall();
    return (stall_pct > 0) && ($urandom_range(99) < stall_pct);
  endfunction

  task automatic put(input stim_t s, input exp_t e);
    st[pc] = s;
    ex[pc] = e;
    pc++;
  endtask

  task automatic idle(input int n);
    stim_t s;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      s = junk();
      if (s.mv) s.we = s.re;
      e = '0;
      e.rdy = 1'b1;
      e.chk_a = (pc == 0);
      e.chk_d = (pc == 0);
      put(s, e);
    end
  endtask

  task automatic header(input logic [AW-1:0] a, input logic [BWD-1:0] b,
                        input logic rd, input logic [DLW-1:0] d);
    stim_t s;
    exp_t e;
    for (int i = 0; i < AW; i++) begin
      if (i > 0) begin
        while (stall()) begin
          s = junk(); s.mv = 1'b0; s.re = rd; s.we = !rd;
          put(s, '0);
        end
      end
      s = junk(); s.mv = 1'b1; s.re = rd; s.we = !rd;
      s.rxa = a[i];
      if (i < BWD) s.rxb = b[i];
      if (i == AW - 1) s.dly = d;
      e = '0;
      e.rdy = (i == 0);
      put(s, e);
    end
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input int b,
                        input logic [DW-1:0] d0);
    stim_t s;
    exp_t e;
    logic [AW-1:0] ad;
    logic [DW-1:0] dat;
    header(a, BWD'(b), 1'b0, DLW'($urandom));
    ad = a;
    for (int j = 0; j <= b; j++) begin
      dat = (j == 0) ? d0 : DW'($urandom);
      for (int k = 0; k < DW; k++) begin
        while (stall()) begin
          s = junk(); s.mv = 1'b0;
          put(s, '0);
        end
        s = junk(); s.mv = 1'b1; s.rxd = dat[k];
        put(s, '0);
      end
      e = '0;
      e.wr = 1'b1; e.chk_a = 1'b1; e.chk_d = 1'b1;
      e.addr = ad; e.wdata = dat; e.done = (j == b);
      put(junk(), e);
      model_mem[ad] = dat;
      ad = ad + 1'b1;
    end
  endtask

  task automatic rd_txn(input logic [AW-1:0] a, input int b,
                        input int d, input int mr_pct);
    stim_t s;
    exp_t e;
    logic [AW-1:0] ad;
    logic [DW-1:0] byt;
    int k;
    header(a, BWD'(b), 1'b1, DLW'(d));
    ad = a;
    for (int j = 0; j <= b; j++) begin
      if (j == 0) begin
        for (int i = 0; i < d; i++) begin
          e = '0; e.split = (d >= TH);
          put(junk(), e);
        end
      end
      e = '0; e.rd = 1'b1; e.chk_a = 1'b1; e.addr = ad;
      put(junk(), e);
      put(junk(), '0);
      byt = model_mem[ad];
      k = 0;
      while (k < DW) begin
        s = junk();
        s.mr = ($urandom_range(99) < mr_pct);
        e = '0; e.vld = 1'b1; e.tx = byt[k];
        if (s.mr) begin
          e.done = (k == DW - 1) && (j == b);
          k++;
        end
        put(s, e);
      end
      ad = ad + 1'b1;
    end
  endtask

  task automatic rst_mid(input logic [AW-1:0] a);
    stim_t s;
    exp_t e;
    header(a, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      s = junk(); s.mv = 1'b1;
      put(s, '0);
    end
    s = junk(); s.rst = 1'b1;
    e = '0; e.rdy = 1'b1; e.chk_a = 1'b1; e.chk_d = 1'b1;
    put(s, e);
  endtask

  function automatic int count_wr(input int a, input int b);
    int n = 0;
    for (int k = a; k < b; k++) if (obs_wr[k]) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int k;
    if (cur_k >= 0) begin
      k = cur_k;
      e = ex[k];
      obs_wr[k] = mem_wr; obs_rd[k] = mem_rd;
      obs_split[k] = split_en; obs_done[k] = done;
      obs_tx[k] = tx_data; obs_addr[k] = mem_addr;
      chk("slave_ready", k, 32'(slave_ready), 32'(e.rdy));
      chk("slave_valid", k, 32'(slave_valid), 32'(e.vld));
      chk("mem_wr", k, 32'(mem_wr), 32'(e.wr));
      chk("mem_rd", k, 32'(mem_rd), 32'(e.rd));
      chk("split_en", k, 32'(split_en), 32'(e.split));
      chk("done", k, 32'(done), 32'(e.done));
      if (e.vld) chk("tx_data", k, 32'(tx_data), 32'(e.tx));
      if (e.chk_a) chk("mem_addr", k, 32'(mem_addr), 32'(e.addr));
      if (e.chk_d) chk("mem_wdata", k, 32'(mem_wdata), 32'(e.wdata));
    end
  end

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] wl [$];
    int nd;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      model_mem[i] = v;
      ram[i] = v;
    end
    model_mem[12'h010] = 8'h96;
    ram[12'h010] = 8'h96;

    idle(2);
    s_w1 = pc; wr_txn(12'h0A5, 0, 8'h3C); idle(1);
    s_r1 = pc; rd_txn(12'h010, 0, 2, 100); idle(1);
    s_r2 = pc; rd_txn(12'h123, 0, 9, 100); e_r2 = pc; idle(1);
    s_b = pc; wr_txn(12'hFFF, 2, 8'h5A); e_b = pc; idle(1);
    s_rst = pc; rst_mid(12'h055); idle(2); e_rst = pc;
    wr_txn(12'h056, 0, 8'hA7); idle(1);
    rd_txn(12'h056, 0, 0, 100); idle(1);
    stall_pct = 30;
    rd_txn(12'hFFE, 2, 0, 50); idle(1);
    while (pc < MAXC - 800) begin
      idle($urandom_range(3));
      if ($urandom_range(1) == 0)
        wr_txn(AW'($urandom), $urandom_range(3), DW'($urandom));
      else
        rd_txn(AW'($urandom), $urandom_range(3),
               ($urandom_range(3) == 0) ? $urandom_range(63)
                                        : $urandom_range(8), 60);
    end
    idle(2);
    ncyc = pc;

    repeat (3) @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      reset = st[k].rst; master_valid = st[k].mv;
      master_ready = st[k].mr; read_en = st[k].re;
      write_en = st[k].we; rx_address = st[k].rxa;
      rx_burst = st[k].rxb; rx_data = st[k].rxd;
      slave_delay = st[k].dly;
      cur_k = k;
    end
    @(posedge clk);
    #1;
    cur_k = -1;
    @(negedge clk);

    chk("pin_w1_wr", s_w1 + 20, 32'(ex[s_w1 + 20].wr), 32'd1);
    chk("pin_w1_data", s_w1 + 20, 32'(ex[s_w1 + 20].wdata), 32'h3C);
    chk("w1_wr_time", s_w1 + 20, 32'(obs_wr[s_w1 + 20]), 32'd1);
    chk("w1_addr", s_w1 + 20, 32'(obs_addr[s_w1 + 20]), 32'h0A5);
    chk("w1_count", s_w1, 32'(count_wr(s_w1, s_r1)), 32'd1);
    chk("pin_r1_rd", s_r1 + 14, 32'(ex[s_r1 + 14].rd), 32'd1);
    chk("r1_rd_time", s_r1 + 14, 32'(obs_rd[s_r1 + 14]), 32'd1);
    v = '0;
    for (int i = 0; i < DW; i++) v[i] = ex[s_r1 + 16 + i].tx;
    chk("pin_r1_byte", s_r1 + 16, 32'(v), 32'h96);
    v = '0;
    for (int i = 0; i < DW; i++) v[i] = obs_tx[s_r1 + 16 + i];
    chk("r1_tx_byte", s_r1 + 16, 32'(v), 32'h96);
    nd = 0;
    for (int k = s_r1; k < s_r2; k++) if (obs_split[k]) nd++;
    chk("r1_no_split", s_r1, 32'(nd), 32'd0);
    nd = 0;
    for (int k = s_r2; k < e_r2; k++) if (obs_split[k]) nd++;
    chk("r2_split_len", s_r2, 32'(nd), 32'd9);
    chk("r2_split_last", s_r2 + 20, 32'(obs_split[s_r2 + 20]), 32'd1);
    chk("r2_split_rload", s_r2 + 22, 32'(obs_split[s_r2 + 22]), 32'd0);
    for (int k = s_b; k < e_b; k++) if (obs_wr[k]) wl.push_back(obs_addr[k]);
    chk("burst_count", s_b, 32'(wl.size()), 32'd3);
    if (wl.size() == 3) begin
      chk("burst_a0", s_b, 32'(wl[0]), 32'hFFF);
      chk("burst_a1", s_b, 32'(wl[1]), 32'h000);
      chk("burst_a2", s_b, 32'(wl[2]), 32'h001);
    end
    nd = 0;
    for (int k = s_b; k < e_b; k++) if (obs_done[k]) nd++;
    chk("burst_done", s_b, 32'(nd), 32'd1);
    chk("rst_no_wr", s_rst, 32'(count_wr(s_rst, e_rst)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
